// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the arbiter request collector
package arb_pkg;

    localparam int MAX_PORTS = 32;
    localparam int IDX_W     = 5;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers zero-extend their grant vector to MAX_PORTS bits.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_req_slot.sv
// rtl/arb_req_slot.sv - one-entry payload slot for a single requesting port
module arb_req_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    // load only ever fires on an empty slot and unload on a full one,
    // so the two are mutually exclusive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/arb_req_collector.sv
// rtl/arb_req_collector.sv - per-port request slots feeding a granted output stage
module arb_req_collector
    import arb_pkg::*;
#(
    parameter int  NUM_PORTS = 4,
    parameter int  DATA_W    = 8,
    localparam int PORT_W    = port_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        in_valid_i,
    output logic [NUM_PORTS-1:0]        in_ready_o,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data_i,
    output logic [NUM_PORTS-1:0]        req_o,
    input  logic [NUM_PORTS-1:0]        gnt_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_W-1:0]           out_data_o,
    output logic [PORT_W-1:0]           out_port_o,
    output logic                        gnt_err_o
);

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] load;
    logic [NUM_PORTS-1:0] unload;
    logic [DATA_W-1:0]    slot_data [NUM_PORTS];

    logic                 take;
    logic                 gnt_any;
    logic                 gnt_onehot;
    logic                 gnt_hits_req;
    logic                 gnt_legal;
    logic                 gnt_illegal;
    logic [DATA_W-1:0]    sel_data;
    logic [PORT_W-1:0]    gnt_idx;

    out_state_t           out_state;
    out_state_t           out_state_next;

    assign in_ready_o = ~full;
    assign req_o      = full;
    assign load       = in_valid_i & ~full;
    assign unload     = gnt_legal ? gnt_i : '0;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
        arb_req_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[k]),
            .unload   (unload[k]),
            .load_data(in_data_i[k*DATA_W +: DATA_W]),
            .full     (full[k]),
            .data     (slot_data[k])
        );
    end

    // Legality uses the registered full vector, so a slot loading this edge is not grantable.
    assign take         = ~out_valid_o | out_ready_i;
    assign gnt_any      = |gnt_i;
    assign gnt_onehot   = gnt_any && ((gnt_i & (gnt_i - 1'b1)) == '0);
    assign gnt_hits_req = |(gnt_i & full);
    assign gnt_legal    = take & gnt_onehot & gnt_hits_req;
    assign gnt_illegal  = take & gnt_any & ~(gnt_onehot & gnt_hits_req);
    assign gnt_idx      = PORT_W'(onehot_to_idx(MAX_PORTS'(gnt_i)));

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_i[k]) begin
                sel_data = sel_data | slot_data[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state <= OUT_EMPTY;
        end else begin
            out_state <= out_state_next;
        end
    end

    always_comb begin
        out_state_next = out_state;
        case (out_state)
            OUT_EMPTY: if (gnt_legal) out_state_next = OUT_FULL;
            OUT_FULL: begin
                if (gnt_legal) begin
                    out_state_next = OUT_FULL;
                end else if (out_ready_i) begin
                    out_state_next = OUT_EMPTY;
                end
            end
            default: out_state_next = OUT_EMPTY;
        endcase
    end

    assign out_valid_o = (out_state == OUT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_o <= '0;
            out_port_o <= '0;
            gnt_err_o  <= 1'b0;
        end else begin
            if (gnt_legal) begin
                out_data_o <= sel_data;
                out_port_o <= gnt_idx;
            end
            if (gnt_illegal) begin
                gnt_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_req_collector.sv
// tb/tb_arb_req_collector.sv - scoreboard bench for arb_req_collector
module tb_arb_req_collector;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     req;
    logic [NP-1:0]     gnt;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [PW-1:0]     out_port;
    logic              gnt_err;

    logic              gnt_mode;
    logic [NP-1:0]     gnt_force;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int pops_mark;
    logic [PW+DW-1:0] sb_q [$];

    always #5 clk = ~clk;

    // Fixed-priority arbiter in the loop unless a grant is being forced.
    assign gnt = gnt_mode ? gnt_force : (req & (~req + 4'd1));

    arb_req_collector #(
        .NUM_PORTS(NP),
        .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .req_o      (req),
        .gnt_i      (gnt),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_port_o (out_port),
        .gnt_err_o  (gnt_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic expect_out(input int port, input logic [DW-1:0] d);
        sb_q.push_back({PW'(port), d});
    endtask

    // Monitor: every accepted output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_pops++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got port %0d data 0x%0h expected none", out_port, out_data);
            end else begin
                logic [PW+DW-1:0] e;
                e = sb_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[DW-1:0]));
                check("out_port", 32'(out_port), 32'(e[PW+DW-1:DW]));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        gnt_mode  = 1'b0;
        gnt_force = '0;

        // Reset then idle
        sample();
        check("rst_in_ready", 32'(in_ready), 32'hF);
        check("rst_req", 32'(req), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_gnt_err", 32'(gnt_err), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_port", 32'(out_port), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Load ports 0,1,3 together; drain one per cycle in priority order
        out_ready = 1'b1;
        in_valid  = 4'b1011;
        in_data   = {8'hA3, 8'h00, 8'hA1, 8'hA0};
        expect_out(0, 8'hA0);
        expect_out(1, 8'hA1);
        expect_out(3, 8'hA3);
        pops_mark = n_pops;
        tick();
        in_valid = '0;
        sample();
        check("t2_req_loaded", 32'(req), 32'hB);
        check("t2_no_out_yet", 32'(out_valid), 32'h0);
        repeat (3) sample();
        check("t2_three_pops", 32'(n_pops - pops_mark), 32'd3);
        check("t2_req_empty", 32'(req), 32'h0);
        sample();
        check("t2_out_drained", 32'(out_valid), 32'h0);

        // Backpressure with ports 2 and 3 full
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b1100;
        in_data   = {8'hB3, 8'hB2, 8'h00, 8'h00};
        expect_out(2, 8'hB2);
        expect_out(3, 8'hB3);
        pops_mark = n_pops;
        tick();
        in_valid = '0;
        sample();
        check("t3_req_both", 32'(req), 32'hC);
        repeat (3) begin
            sample();
            check("t3_hold_valid", 32'(out_valid), 32'h1);
            check("t3_hold_data", 32'(out_data), 32'hB2);
            check("t3_hold_port", 32'(out_port), 32'h2);
            check("t3_hold_req", 32'(req), 32'h8);
        end
        tick();
        out_ready = 1'b1;
        sample();
        sample();
        check("t3_b2b_pops", 32'(n_pops - pops_mark), 32'd2);
        sample();
        check("t3_drained", 32'(out_valid), 32'h0);

        // Multi-hot grant with only slot 1 full
        tick();
        gnt_mode  = 1'b1;
        gnt_force = '0;
        in_valid  = 4'b0010;
        in_data   = {8'h00, 8'h00, 8'hC1, 8'h00};
        tick();
        in_valid  = '0;
        gnt_force = 4'b0110;
        tick();
        gnt_force = '0;
        sample();
        check("t4_err_set", 32'(gnt_err), 32'h1);
        check("t4_no_xfer", 32'(out_valid), 32'h0);
        check("t4_req_kept", 32'(req), 32'h2);
        tick();
        expect_out(1, 8'hC1);
        pops_mark = n_pops;
        gnt_force = 4'b0010;
        tick();
        gnt_force = '0;
        sample();
        check("t4_legal_pop", 32'(n_pops - pops_mark), 32'd1);
        check("t4_err_sticky", 32'(gnt_err), 32'h1);
        check("t4_req_clear", 32'(req), 32'h0);

        // One-hot grant to an empty slot
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample();
        check("t5_err_cleared", 32'(gnt_err), 32'h0);
        tick();
        in_valid = 4'b0001;
        in_data  = {8'h00, 8'h00, 8'h00, 8'hE0};
        tick();
        in_valid  = '0;
        gnt_force = 4'b1000;
        tick();
        gnt_force = '0;
        sample();
        check("t5_err_set", 32'(gnt_err), 32'h1);
        check("t5_no_xfer", 32'(out_valid), 32'h0);
        check("t5_req_kept", 32'(req), 32'h1);
        tick();
        expect_out(0, 8'hE0);
        gnt_mode = 1'b0;
        repeat (3) sample();
        check("t5_drained", 32'(req), 32'h0);

        // Asynchronous reset mid-operation; nothing in flight may appear afterwards
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b0101;
        in_data   = {8'h00, 8'hD2, 8'h00, 8'hD0};
        tick();
        in_valid = '0;
        tick();
        in_valid = 4'b0001;
        in_data  = {8'h00, 8'h00, 8'h00, 8'hD4};
        tick();
        in_valid = '0;
        sample();
        check("t6_pre_valid", 32'(out_valid), 32'h1);
        check("t6_pre_req", 32'(req), 32'h5);
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'h0);
        check("t6_async_req", 32'(req), 32'h0);
        check("t6_async_ready", 32'(in_ready), 32'hF);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        pops_mark = n_pops;
        repeat (8) sample();
        check("t6_no_stale", 32'(n_pops - pops_mark), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_req_collector.md
# arb_req_collector

Requester-side companion to the fixed priority arbiter. It accepts payloads on NUM_PORTS independent valid/ready input ports and holds each in a one-entry slot. It presents the occupancy of those slots as a request vector to an external arbiter. It then takes the arbiter's one-hot grant and moves the granted slot's payload into a registered output stage with a valid/ready handshake toward the downstream consumer.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesting ports (≥2)
- DATA_W, 8, payload width per port

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid_i  in  NUM_PORTS  per-port payload valid
- in_ready_o  out  NUM_PORTS  per-port slot free
- in_data_i  in  NUM_PORTS*DATA_W  per-port payload; port k occupies bits [k*DATA_W +: DATA_W]
- req_o  out  NUM_PORTS  request vector to arbiter, bit k = slot k full
- gnt_i  in  NUM_PORTS  grant vector from arbiter, expected one-hot or zero
- out_valid_o  out  1  output stage holds a payload
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  granted payload
- out_port_o  out  PORT_W  index of the port the payload came from
- gnt_err_o  out  1  sticky flag for an illegal grant

## Operation
- Slot k: in_ready_o[k] = ~full[k].
  - Load on in_valid_i[k] & in_ready_o[k].
  - Full slots ignore in_valid_i.
  - req_o = full vector, driven directly from registers.
- take = ~out_valid_o | out_ready_i. The output stage can accept a new payload when take is high.
- Grant legality is checked only when take = 1:
  - gnt_i = 0: no transfer.
  - Legal grant: gnt_i is one-hot and (gnt_i & req_o) ≠ 0. On the clock edge, out_data_o gets that slot's data, out_port_o gets its index, out_valid_o is set, and full[k] is cleared.
  - Illegal grant (multi-hot, or one-hot to an empty slot): no transfer, no slot change, gnt_err_o set.
- When take = 0, gnt_i is ignored entirely, including the legality check.
- If out_valid_o & out_ready_i and there is no legal grant, out_valid_o clears.
- Output stage states:
  - EMPTY → FULL on a legal grant.
  - FULL → FULL on out_ready_i with a legal grant (back-to-back transfer).
  - FULL → EMPTY on out_ready_i with no legal grant.
  - FULL holds while out_ready_i = 0. out_data_o and out_port_o stay stable throughout.
- Slot freeing and reload: a slot freed on edge N shows in_ready_o = 1 after N and can be reloaded at edge N+1. There is no same-cycle unload and reload.
- gnt_err_o stays set until reset.

## Timing
- Reset values: all slots empty, req_o = 0, in_ready_o = all 1, out_valid_o = 0, out_data_o = 0, out_port_o = 0, gnt_err_o = 0.
- Reset asserted mid-operation discards all slot contents and the output payload immediately (asynchronous). Nothing in flight is delivered.
- Latencies:
  - Input accept edge to req_o bit high: 1 cycle.
  - Legal grant edge to out_valid_o: 1 cycle.
  - Minimum input-to-output latency: 2 cycles, provided the arbiter's grant is combinational from req_o.
- Throughput:
  - Aggregate: one payload per cycle when several slots are full and out_ready_i = 1.
  - Single port: one payload per 2 cycles.
- A grant may arrive in the same cycle a slot is being loaded. The legality check uses registered req_o, so a slot that is filling on this edge is not yet grantable.

## Structure
- Package arb_pkg:
  - PORT_W = $clog2(NUM_PORTS) helper function.
  - Output-stage state enum {OUT_EMPTY, OUT_FULL}.
  - onehot_to_idx function, shared with the arbiter bench.
- Sub-module arb_req_slot, one instance per port (generate loop). It holds the full flag and data register and exposes load, unload, full and data.
- Top level owns the grant check, index encode and output stage.

## Test plan
- Reset then idle: in_ready_o = 4'b1111, req_o = 0, out_valid_o = 0, gnt_err_o = 0.
- Fixed-priority arbiter in loop: load ports 0, 1, 3 with data 0xA0, 0xA1, 0xA3 in one cycle, out_ready_i = 1.
  - req_o = 4'b1011 on the next cycle.
  - Outputs appear on consecutive cycles: 0xA0 (port 0), 0xA1 (port 1), 0xA3 (port 3).
  - req_o then returns to 0.
- Backpressure: hold out_ready_i = 0 with ports 2 and 3 full.
  - The first granted payload is held stable, and the other slot keeps its request.
  - Raise out_ready_i: both payloads are delivered back-to-back.
- Illegal grant: force gnt_i = 4'b0110 with only slot 1 full.
  - No transfer, gnt_err_o = 1 and stays set.
  - A subsequent legal gnt_i = 4'b0010 delivers the payload normally.
- Grant to empty slot: gnt_i = 4'b1000 while req_o = 4'b0001 → no transfer, gnt_err_o = 1.
- Reset mid-operation: assert reset while out_valid_o = 1 and slots 0 and 2 are full.
  - out_valid_o = 0, req_o = 0, in_ready_o = 4'b1111 without waiting for a clock edge.
  - After reset, no stale payload ever appears.
